// File: rtl/if_id_skid_stage_pkg.sv
// rtl/if_id_skid_stage_pkg.sv - shared constants and occupancy encoding for the IF->ID stage
package if_id_skid_stage_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [7:0]  INT_NONE = 8'h00;

  // Hold-flag bus levels, ordered so deeper stages dominate
  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b010;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/if_id_skid_stage_pipe_payload_reg.sv
// rtl/if_id_skid_stage_pipe_payload_reg.sv - load-enabled payload register with async reset value
module pipe_payload_reg #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF->ID pipeline stage with valid/ready handshake and 2-entry skid buffer
module if_id_skid_stage #(
  parameter int                 INST_W     = 32,
  parameter int                 ADDR_W     = 32,
  parameter int                 INT_W      = 8,
  parameter int                 HOLD_W     = 3,
  parameter logic [HOLD_W-1:0]  HOLD_LEVEL = HOLD_W'(if_id_skid_stage_pkg::HOLD_PC),
  parameter logic [INST_W-1:0]  NOP_INST   = INST_W'(if_id_skid_stage_pkg::INST_NOP),
  parameter logic [INT_W-1:0]   INT_NONE   = INT_W'(if_id_skid_stage_pkg::INT_NONE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o,
  output logic [1:0]        occupancy_o
);

  import if_id_skid_stage_pkg::*;

  localparam int               PAY_W   = INST_W + ADDR_W + INT_W;
  localparam logic [PAY_W-1:0] PAY_NOP = {NOP_INST, {ADDR_W{1'b0}}, INT_NONE};

  occ_e             occ_q, occ_d;
  logic             s_ready_q;
  logic             hold_en, acc, in_acc;
  logic             load_main, load_skid, main_from_skid;
  logic [PAY_W-1:0] in_payload, main_d, main_q, skid_q;

  assign hold_en    = (hold_flag_i >= HOLD_LEVEL);
  assign m_valid_o  = (occ_q != OCC_EMPTY);
  assign s_ready_o  = s_ready_q;
  assign acc        = m_valid_o & m_ready_i & ~hold_en;
  assign in_acc     = s_valid_i & s_ready_q;
  assign in_payload = {inst_i, inst_addr_i, int_flag_i};
  assign main_d     = main_from_skid ? skid_q : in_payload;

  always_comb begin
    occ_d          = occ_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (in_acc) begin
            load_main = 1'b1;
            occ_d     = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && in_acc) begin
            load_main = 1'b1;
          end else if (acc) begin
            occ_d = OCC_EMPTY;
          end else if (in_acc) begin
            load_skid = 1'b1;
            occ_d     = OCC_TWO;
          end
        end
        OCC_TWO: begin
          if (acc) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            occ_d          = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Ready is computed from the next occupancy so it never depends on m_ready_i combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q     <= OCC_EMPTY;
      s_ready_q <= 1'b1;
    end else begin
      occ_q     <= occ_d;
      s_ready_q <= (occ_d != OCC_TWO);
    end
  end

  pipe_payload_reg #(.W(PAY_W), .RST_VAL(PAY_NOP)) u_main_reg (
    .clk (clk),
    .rst (rst),
    .en  (load_main),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_payload_reg #(.W(PAY_W), .RST_VAL(PAY_NOP)) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .en  (load_skid),
    .d   (in_payload),
    .q   (skid_q)
  );

  assign {inst_o, inst_addr_o, int_flag_o} = m_valid_o ? main_q : PAY_NOP;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - scoreboard bench for the IF->ID skid stage
module tb_if_id_skid_stage;

  localparam logic [2:0]  HOLD_LEVEL = 3'd1;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  hold_flag_i = 3'd0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic [7:0]  int_flag_i = '0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [7:0]  int_flag_o;
  logic [1:0]  occupancy_o;

  int tests = 0;
  int fails = 0;

  logic [71:0] sb_q[$];
  int          model_occ = 0;

  always #5 clk = ~clk;

  if_id_skid_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .hold_flag_i (hold_flag_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .int_flag_i  (int_flag_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .int_flag_o  (int_flag_o),
    .occupancy_o (occupancy_o)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] adr, input logic [7:0] itf);
    s_valid_i   = v;
    inst_i      = ins;
    inst_addr_i = adr;
    int_flag_i  = itf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: bench-side occupancy model decides what is accepted and consumed each edge
  always @(negedge clk) begin
    logic hold_m, acc_m, in_m;
    logic [71:0] exp_pay;
    if (!rst) begin
      model_occ = 0;
      sb_q.delete();
    end else begin
      check("mon_occupancy", {70'd0, occupancy_o}, 72'(model_occ));
      check("mon_s_ready", {71'd0, s_ready_o}, {71'd0, model_occ != 2});
      hold_m = (hold_flag_i >= HOLD_LEVEL);
      acc_m  = (model_occ != 0) && m_ready_i && !hold_m;
      in_m   = s_valid_i && (model_occ != 2);
      if (flush_i) begin
        model_occ = 0;
        sb_q.delete();
      end else begin
        if (acc_m) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", {inst_o, inst_addr_o, int_flag_o}, 72'hx);
          end else begin
            exp_pay = sb_q.pop_front();
            check("sb_payload", {inst_o, inst_addr_o, int_flag_o}, exp_pay);
          end
          model_occ = model_occ - 1;
        end
        if (in_m) begin
          sb_q.push_back({inst_i, inst_addr_i, int_flag_i});
          model_occ = model_occ + 1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_valid", {71'd0, m_valid_o}, 72'd0);
    check("rst_ready", {71'd0, s_ready_o}, 72'd1);
    check("rst_payload", {inst_o, inst_addr_o, int_flag_o}, {NOP, 32'd0, 8'd0});
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("idle_valid", {71'd0, m_valid_o}, 72'd0);
    check("idle_inst", {40'd0, inst_o}, {40'd0, NOP});
    check("idle_occ", {70'd0, occupancy_o}, 72'd0);

    // Streaming at full rate
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 32'(4 * i), 8'(i + 1));
      tick();
      check("stream_out", {m_valid_o, inst_o, inst_addr_o, int_flag_o},
            {1'b1, 32'hA000_0000 + 32'(i), 32'(4 * i), 8'(i + 1)});
    end
    drive(1'b0, '0, '0, '0);
    tick();
    check("stream_drained", {71'd0, m_valid_o}, 72'd0);

    // Back-pressure fills both entries
    m_ready_i = 1'b0;
    drive(1'b1, 32'hB000_0000, 32'h100, 8'h11);
    tick();
    drive(1'b1, 32'hB000_0001, 32'h104, 8'h12);
    tick();
    drive(1'b0, '0, '0, '0);
    check("bp_occ", {70'd0, occupancy_o}, 72'd2);
    check("bp_ready", {71'd0, s_ready_o}, 72'd0);
    check("bp_head", {40'd0, inst_o}, {40'd0, 32'hB000_0000});
    m_ready_i = 1'b1;
    tick();
    check("bp_second", {m_valid_o, inst_o}, {1'b1, 32'hB000_0001});
    tick();
    check("bp_empty", {71'd0, m_valid_o}, 72'd0);

    // Hold freezes the output while input still fills the skid
    hold_flag_i = HOLD_LEVEL;
    drive(1'b1, 32'hC000_0000, 32'h200, 8'h21);
    tick();
    check("hold_h0_a", {40'd0, inst_o}, {40'd0, 32'hC000_0000});
    drive(1'b1, 32'hC000_0001, 32'h204, 8'h22);
    tick();
    check("hold_h0_b", {40'd0, inst_o}, {40'd0, 32'hC000_0000});
    drive(1'b1, 32'hC000_0002, 32'h208, 8'h23);
    tick();
    check("hold_h0_c", {inst_o, inst_addr_o, int_flag_o}, {32'hC000_0000, 32'h200, 8'h21});
    check("hold_occ", {70'd0, occupancy_o}, 72'd2);
    hold_flag_i = 3'd0;
    tick();
    check("hold_rel_h1", {m_valid_o, inst_o}, {1'b1, 32'hC000_0001});
    tick();
    check("hold_rel_h2", {m_valid_o, inst_o}, {1'b1, 32'hC000_0002});
    drive(1'b0, '0, '0, '0);
    tick();
    check("hold_empty", {71'd0, m_valid_o}, 72'd0);

    // Flush in the full state with input offered
    m_ready_i = 1'b0;
    drive(1'b1, 32'hD000_0000, 32'h300, 8'h31);
    tick();
    drive(1'b1, 32'hD000_0001, 32'h304, 8'h32);
    tick();
    drive(1'b1, 32'hD000_0002, 32'h308, 8'h33);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, '0, '0, '0);
    check("flush_out", {m_valid_o, inst_o, inst_addr_o, int_flag_o}, {1'b0, NOP, 32'd0, 8'd0});
    check("flush_occ", {70'd0, occupancy_o}, 72'd0);
    check("flush_ready", {71'd0, s_ready_o}, 72'd1);
    m_ready_i = 1'b1;
    tick();
    tick();
    check("flush_no_ghost", {71'd0, m_valid_o}, 72'd0);

    // Asynchronous reset while full
    m_ready_i = 1'b0;
    drive(1'b1, 32'hE000_0000, 32'h400, 8'h41);
    tick();
    drive(1'b1, 32'hE000_0001, 32'h404, 8'h42);
    tick();
    drive(1'b0, '0, '0, '0);
    check("arst_pre_occ", {70'd0, occupancy_o}, 72'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out", {m_valid_o, inst_o, inst_addr_o, int_flag_o}, {1'b0, NOP, 32'd0, 8'd0});
    check("arst_occ_ready", {69'd0, occupancy_o, s_ready_o}, 72'd1);
    tick();
    rst = 1'b1;
    m_ready_i = 1'b1;
    tick();
    tick();
    check("arst_after", {71'd0, m_valid_o}, 72'd0);

    check("sb_empty_at_end", 72'(sb_q.size()), 72'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF→ID pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
- Carries instruction, instruction address and interrupt flags from fetch to decode.
- Stalls on either the shared hold-flag bus or decode back-pressure, without dropping or duplicating an instruction.
- Flush inserts a bubble: the output presents a NOP with `m_valid_o` low.
- `s_ready_o` is registered, so there is no combinational path from `m_ready_i` to the fetch side.

## Interface
Parameters:
- `INST_W`, 32, instruction width.
- `ADDR_W`, 32, instruction address width.
- `INT_W`, 8, interrupt flag width.
- `HOLD_W`, 3, hold-flag bus width.
- `HOLD_LEVEL`, 1, stage holds when `hold_flag_i >= HOLD_LEVEL` (unsigned compare).
- `NOP_INST`, 32'h0000_0013, instruction value shown when empty or flushed.
- `INT_NONE`, 0, interrupt value shown when empty or flushed.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush_i` in 1: discard all held entries.
- `hold_flag_i` in `HOLD_W`: pipeline hold level.
- `s_valid_i` in 1: fetch has a valid instruction.
- `s_ready_o` out 1: stage can accept.
- `inst_i` in `INST_W`: instruction from fetch.
- `inst_addr_i` in `ADDR_W`: instruction address from fetch.
- `int_flag_i` in `INT_W`: interrupt flags from fetch.
- `m_valid_o` out 1: output entry valid.
- `m_ready_i` in 1: decode accepts.
- `inst_o` out `INST_W`: instruction to decode.
- `inst_addr_o` out `ADDR_W`: instruction address to decode.
- `int_flag_o` out `INT_W`: interrupt flags to decode.
- `occupancy_o` out 2: number of entries held, 0..2.

## Operation
Internal signals:
- `hold_en = (hold_flag_i >= HOLD_LEVEL)`.
- `acc = m_valid_o & m_ready_i & ~hold_en`: output entry consumed.
- `in_acc = s_valid_i & s_ready_o`: input entry accepted.

Storage: main register (drives outputs) and skid register. State is encoded by occupancy:
- EMPTY (0): `in_acc` → load main, go to ONE.
- ONE (1):
  - `acc & in_acc` → main ← input, stay in ONE.
  - `acc & ~in_acc` → go to EMPTY.
  - `~acc & in_acc` → skid ← input, go to TWO.
  - otherwise hold.
- TWO (2): `s_ready_o` = 0. On `acc` → main ← skid, go to ONE; otherwise hold.

Output and ready rules:
- `s_ready_o = (occupancy != 2)`, registered.
- When `m_valid_o` = 0: `inst_o = NOP_INST`, `inst_addr_o = 0`, `int_flag_o = INT_NONE`, regardless of stale register contents.

Flush:
- Highest priority; overrides `in_acc` and `acc` in the same cycle.
- Next state is EMPTY; any input presented in the flush cycle is dropped.

Hold:
- While `hold_en`, no entry leaves.
- Input is still accepted until the skid register is full.
- Payload is never altered while held.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State EMPTY, `m_valid_o` = 0, `s_ready_o` = 1, `occupancy_o` = 0.
  - `inst_o = NOP_INST`, `inst_addr_o = 0`, `int_flag_o = INT_NONE`.
- Reset mid-operation discards both entries immediately; no partial payload is visible.
- Latency: 1 cycle from `in_acc` to `m_valid_o`. Throughput: 1 instruction/cycle with `m_ready_i` = 1 and no hold.
- Ordering: strict FIFO. The skid entry always leaves after the main entry.
- After a flush: `m_valid_o` = 0 and `s_ready_o` = 1 on the following cycle.
- The cycle after `s_ready_o` drops, the fetch side must hold `s_valid_i` and its payload stable until accepted.
- Back-to-back stalls: at most 2 entries are ever held; no overflow is possible.

## Structure
- Shared package/defines holds `NOP_INST` (`INST_NOP`), `INT_NONE`, `ZeroWord` and the hold-level encodings.
- One sub-module, `pipe_payload_reg`:
  - Width-parametrised register with load enable and async active-low reset to a parameter value.
  - Instantiated twice (main, skid) over the concatenated `{inst, addr, int}` payload.
- State lives in the top module as the 2-bit occupancy counter.

## Test plan
- Reset then idle → `m_valid_o` = 0, `inst_o` = 32'h13, `s_ready_o` = 1, `occupancy_o` = 0.
- Stream A0..A3 (addr 0x0, 0x4, 0x8, 0xC) with `m_ready_i` = 1 → each appears on the output 1 cycle after input, in order, no gaps.
- `m_ready_i` = 0 while A, B presented → `occupancy_o` = 2, `s_ready_o` = 0; release → A, then B on consecutive cycles, no loss or duplicate.
- `hold_flag_i` = HOLD_LEVEL for 3 cycles with `m_ready_i` = 1 → output frozen on the same entry; drains in order after hold clears.
- `flush_i` in TWO state with `s_valid_i` = 1 → next cycle `m_valid_o` = 0, `inst_o` = 32'h13, `int_flag_o` = 0, `occupancy_o` = 0; flushed input never appears.
- `rst` asserted asynchronously mid-stream while in TWO → outputs return to reset values before the next clock edge.
